// File: rtl/usb_output.sv
// FT245 transmit path: buffers outgoing bytes in a small FIFO and writes each
// one to the FTDI chip using the TXE#/WR handshake.
module usb_output #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 3,
    parameter int HOLD_CYCLES    = 1,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_din,
    input  logic        i_din_valid,
    output logic        o_din_ready,
    input  logic        i_txe,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    output logic        o_wr,
    output logic        o_busy,
    output logic [15:0] o_bytes_sent,
    output logic [2:0]  o_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    localparam logic [7:0]      SETUP_LAST   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0]      STROBE_LAST  = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0]      HOLD_LAST    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]      RECOVER_LAST = 8'(RECOVER_CYCLES - 1);
    localparam logic [ADDR_W:0] FULL_CNT     = (ADDR_W + 1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0] r_count;

    logic            r_txe_m;
    logic            r_txe_s;

    logic [2:0]      r_state;
    logic [7:0]      r_tcnt;
    logic [7:0]      r_data_out;
    logic            r_data_oe;
    logic            r_wr;
    logic [15:0]     r_bytes_sent;

    logic            w_push;
    logic            w_pop;

    assign o_din_ready = (r_count != FULL_CNT);
    assign w_push      = i_din_valid & o_din_ready;
    // The FSM is the only consumer; it pops exactly when it launches a write.
    assign w_pop       = (r_state == S_IDLE) & (r_count != '0) & ~r_txe_s;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Reset to 1 so nothing is written until the chip reports room.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txe_m <= 1'b1;
            r_txe_s <= 1'b1;
        end else begin
            r_txe_m <= i_txe;
            r_txe_s <= r_txe_m;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_tcnt       <= '0;
            r_data_out   <= '0;
            r_data_oe    <= 1'b0;
            r_wr         <= 1'b0;
            r_bytes_sent <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_data_out <= r_mem[r_rptr];
                        r_data_oe  <= 1'b1;
                        r_tcnt     <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_tcnt == SETUP_LAST) begin
                        r_tcnt  <= '0;
                        r_wr    <= 1'b1;
                        r_state <= S_STROBE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_STROBE: begin
                    if (r_tcnt == STROBE_LAST) begin
                        r_tcnt  <= '0;
                        r_wr    <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_tcnt == HOLD_LAST) begin
                        r_tcnt       <= '0;
                        r_data_oe    <= 1'b0;
                        r_bytes_sent <= r_bytes_sent + 1'b1;
                        r_state      <= S_RECOVER;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                // TXE# lags through the synchronizer, so ignore it for a while.
                S_RECOVER: begin
                    if (r_tcnt == RECOVER_LAST) begin
                        r_tcnt  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    r_tcnt    <= '0;
                    r_wr      <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_oe    = r_data_oe;
    assign o_wr         = r_wr;
    assign o_bytes_sent = r_bytes_sent;
    assign o_state      = r_state;
    assign o_busy       = (r_count != '0) | (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_output.sv
// Directed bench for usb_output: reset, single write timing, full FIFO,
// TXE# backpressure, simultaneous push/pop and reset during a strobe.
module tb_usb_output;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        txe;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        wr;
    logic        busy;
    logic [15:0] bytes_sent;
    logic [2:0]  state;

    int n_checks;
    int n_errors;

    logic [7:0] sent_q[$];
    logic       wr_q;

    usb_output dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_din_ready  (din_ready),
        .i_txe        (txe),
        .o_data_out   (data_out),
        .o_data_oe    (data_oe),
        .o_wr         (wr),
        .o_busy       (busy),
        .o_bytes_sent (bytes_sent),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log the data bus at every rising edge of wr.
    always @(negedge clk) begin
        if (wr && !wr_q)
            sent_q.push_back(data_out);
        wr_q <= wr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_wr(input int maxc);
        for (int i = 0; i < maxc && !wr; i++) @(negedge clk);
        chk("wait_wr", wr, 1);
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc && busy; i++) @(negedge clk);
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc);
        for (int i = 0; i < maxc && state != s; i++) @(negedge clk);
        chk("wait_state", state, s);
    endtask

    initial begin
        int base;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        txe       = 1'b1;
        wr_q      = 1'b0;

        // 1. reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr", wr, 0);
        chk("rst_oe", data_oe, 0);
        chk("rst_ready", din_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bytes", bytes_sent, 0);
        chk("rst_state", state, 0);
        chk("rst_dout", data_out, 0);

        // 2. single byte timing
        txe = 1'b0;
        repeat (3) @(negedge clk);
        base = sent_q.size();
        din       = 8'hA5;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        chk("t2_k0_state", state, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    chk("t2_k1_state", state, 1);
                    chk("t2_k1_wr", wr, 0);
                    chk("t2_k1_oe", data_oe, 1);
                    chk("t2_k1_dout", data_out, 8'hA5);
                end
                2, 3, 4: begin
                    chk("t2_strobe_wr", wr, 1);
                    chk("t2_strobe_state", state, 2);
                    chk("t2_strobe_dout", data_out, 8'hA5);
                end
                5: begin
                    chk("t2_k5_wr", wr, 0);
                    chk("t2_k5_state", state, 3);
                    chk("t2_k5_oe", data_oe, 1);
                    chk("t2_k5_dout", data_out, 8'hA5);
                end
                6: begin
                    chk("t2_k6_state", state, 4);
                    chk("t2_k6_oe", data_oe, 0);
                    chk("t2_k6_bytes", bytes_sent, 1);
                end
                9: begin
                    chk("t2_k9_state", state, 4);
                    chk("t2_k9_busy", busy, 1);
                end
                10: begin
                    chk("t2_k10_state", state, 0);
                    chk("t2_k10_busy", busy, 0);
                end
                default: ;
            endcase
        end
        chk("t2_nsent", sent_q.size() - base, 1);
        chk("t2_byte", sent_q[base], 8'hA5);

        // 3. backpressure and full FIFO
        txe = 1'b1;
        do_reset();
        base = sent_q.size();
        for (int i = 0; i < 16; i++) begin
            chk("t3_ready_pre", din_ready, 1);
            push(8'(i));
        end
        chk("t3_full_ready", din_ready, 0);
        chk("t3_full_busy", busy, 1);
        din       = 8'hEE;
        din_valid = 1'b1;
        repeat (3) @(negedge clk);
        din_valid = 1'b0;
        chk("t3_ready_held", din_ready, 0);
        chk("t3_no_wr", sent_q.size() - base, 0);
        txe = 1'b0;
        wait_idle(200);
        chk("t3_nsent", sent_q.size() - base, 16);
        for (int i = 0; i < 16; i++)
            chk("t3_order", (sent_q.size() > base + i) ? sent_q[base + i] : 8'hFF, 8'(i));
        chk("t3_bytes", bytes_sent, 16);
        chk("t3_ready_after", din_ready, 1);

        // 4. txe rises during STROBE
        do_reset();
        txe = 1'b0;
        repeat (3) @(negedge clk);
        base = sent_q.size();
        push(8'h11);
        push(8'h22);
        wait_wr(10);
        txe = 1'b1;
        wait_state(3'd4, 10);
        chk("t4_bytes1", bytes_sent, 1);
        repeat (8) @(negedge clk);
        chk("t4_blocked_wr", wr, 0);
        chk("t4_blocked_state", state, 0);
        chk("t4_blocked_busy", busy, 1);
        chk("t4_blocked_n", sent_q.size() - base, 1);
        txe = 1'b0;
        wait_idle(40);
        chk("t4_bytes2", bytes_sent, 2);
        chk("t4_nsent", sent_q.size() - base, 2);
        chk("t4_b0", sent_q[base], 8'h11);
        chk("t4_b1", (sent_q.size() > base + 1) ? sent_q[base + 1] : 8'hFF, 8'h22);

        // 5. push on the same edge as the IDLE->SETUP pop
        txe = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        base = sent_q.size();
        push(8'h31);
        push(8'h32);
        push(8'h33);
        txe = 1'b0;
        repeat (2) @(negedge clk);
        din       = 8'h34;
        din_valid = 1'b1;
        chk("t5_state_pre", state, 0);
        chk("t5_ready", din_ready, 1);
        @(negedge clk);
        din_valid = 1'b0;
        chk("t5_state_setup", state, 1);
        chk("t5_dout", data_out, 8'h31);
        wait_idle(80);
        chk("t5_nsent", sent_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            chk("t5_order", (sent_q.size() > base + i) ? sent_q[base + i] : 8'hFF, 8'h31 + 8'(i));
        chk("t5_bytes", bytes_sent, 4);

        // 6. reset asserted mid-strobe
        do_reset();
        txe = 1'b0;
        repeat (3) @(negedge clk);
        push(8'h5A);
        push(8'h5B);
        push(8'h5C);
        wait_wr(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_wr", wr, 0);
        chk("t6_oe", data_oe, 0);
        chk("t6_ready", din_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_bytes", bytes_sent, 0);
        chk("t6_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_after_state", state, 0);
        chk("t6_after_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
